// File: rtl/gfx_compositor.sv
// VGA timing, prioritised layer compositor with double-buffered palette, PIPE-aligned RGB/sync,
// frame/game/row ticks and sticky collision. Optional: GFX_BLANK_DEBUG_EN colours blanking pixels.
module gfx_compositor #(
  parameter int         NUM_LAYERS = 4,
  parameter int         CONV       = 0,
  parameter int         PIPE       = 2,
  parameter int         H_ACTIVE   = 640,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_ACTIVE   = 480,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33,
  parameter int         TICK_DIV   = 3,
  parameter int         ROW_BIT    = 5,
  parameter int         COLL_A     = 0,
  parameter int         COLL_B     = 1,
  parameter logic [5:0] BG_COLOR   = 6'h00,
  localparam int        LAW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_LAYERS-1:0] i_layer,
  input  logic                  i_pal_we,
  input  logic [LAW-1:0]        i_pal_addr,
  input  logic [5:0]            i_pal_data,
  input  logic                  i_coll_clr,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic [1:0]            o_red,
  output logic [1:0]            o_green,
  output logic [1:0]            o_blue,
  output logic [9:CONV]         o_hpos,
  output logic [9:CONV]         o_vpos,
  output logic                  o_frame_tick,
  output logic                  o_game_tick,
  output logic                  o_game_tick_r,
  output logic                  o_row_tick,
  output logic                  o_collision,
  output logic                  o_coll_sticky
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int         FCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(TICK_DIV - 1);
`ifdef GFX_BLANK_DEBUG_EN
  localparam logic [5:0] BLANK_COLOR = 6'b00_10_11;
`else
  localparam logic [5:0] BLANK_COLOR = 6'h00;
`endif

  logic [9:0]     hpos_q, hpos_d, vpos_q, vpos_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [5:0]     shadow_q [NUM_LAYERS];
  logic [5:0]     shadow_d [NUM_LAYERS];
  logic [5:0]     active_q [NUM_LAYERS];
  logic [5:0]     active_d [NUM_LAYERS];
  logic [7:0]     pipe_q   [PIPE];
  logic [7:0]     pipe_d   [PIPE];
  logic           game_r_q, game_r_d;
  logic           row_bit_q, row_bit_d;
  logic           sticky_q, sticky_d;
  logic           display_on, hs_n, vs_n;
  logic [5:0]     color0;

  always_comb begin
    display_on   = (hpos_q < H_ACT) && (vpos_q < V_ACT);
    hs_n         = !((hpos_q >= HS_START) && (hpos_q < HS_END));
    vs_n         = !((vpos_q >= VS_START) && (vpos_q < VS_END));
    o_frame_tick = rst_n && (hpos_q == 10'd0) && (vpos_q == 10'd0);
    o_game_tick  = o_frame_tick && (fcnt_q == FC_LAST);
    o_row_tick   = rst_n && vpos_q[ROW_BIT] && !row_bit_q;
    o_collision  = rst_n && display_on && i_layer[COLL_A] && i_layer[COLL_B];

    hpos_d = (hpos_q == H_LAST) ? 10'd0 : hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (hpos_q == H_LAST)
      vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;

    fcnt_d = fcnt_q;
    if (o_frame_tick)
      fcnt_d = (fcnt_q == FC_LAST) ? '0 : fcnt_q + 1'b1;

    // A write in the copy cycle only reaches the shadow, so it waits for the next frame.
    shadow_d = shadow_q;
    if (i_pal_we && (int'(i_pal_addr) < NUM_LAYERS))
      shadow_d[i_pal_addr] = i_pal_data;
    active_d = o_frame_tick ? shadow_q : active_q;

    // Pixel (0,0) already uses the freshly copied palette; lowest index wins.
    color0 = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (i_layer[i]) color0 = active_d[i];
    if (!display_on) color0 = BLANK_COLOR;

    pipe_d[0] = {hs_n, vs_n, color0};
    for (int i = 1; i < PIPE; i++)
      pipe_d[i] = pipe_q[i-1];

    game_r_d  = o_game_tick;
    row_bit_d = vpos_q[ROW_BIT];
    sticky_d  = o_collision ? 1'b1 : (i_coll_clr ? 1'b0 : sticky_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q    <= '0;
      vpos_q    <= '0;
      fcnt_q    <= '0;
      game_r_q  <= 1'b0;
      row_bit_q <= 1'b0;
      sticky_q  <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= 6'h3F;
        active_q[i] <= 6'h3F;
      end
      for (int i = 0; i < PIPE; i++)
        pipe_q[i] <= 8'hC0;
    end else begin
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      fcnt_q    <= fcnt_d;
      game_r_q  <= game_r_d;
      row_bit_q <= row_bit_d;
      sticky_q  <= sticky_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pipe_q    <= pipe_d;
    end
  end

  assign {o_hsync, o_vsync, o_red, o_green, o_blue} = pipe_q[PIPE-1];
  assign o_hpos        = hpos_q[9:CONV];
  assign o_vpos        = vpos_q[9:CONV];
  assign o_game_tick_r = game_r_q;
  assign o_coll_sticky = sticky_q;

endmodule

// File: tb/tb_gfx_compositor.sv
// Randomised bench for gfx_compositor on a shrunken raster, checked each cycle
// against a model derived from elapsed cycles since reset release.
module tb_gfx_compositor;
  localparam int NL = 4, PIPE = 2, TD = 3, RB = 2;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [5:0] BG = 6'h15;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] i_layer = '0;
  logic       i_pal_we = 1'b0;
  logic [1:0] i_pal_addr = '0;
  logic [5:0] i_pal_data = '0;
  logic       i_coll_clr = 1'b0;
  logic       o_hsync, o_vsync, o_frame_tick, o_game_tick, o_game_tick_r;
  logic       o_row_tick, o_collision, o_coll_sticky;
  logic [1:0] o_red, o_green, o_blue;
  logic [9:0] o_hpos, o_vpos;

  always #5 clk = ~clk;

  gfx_compositor #(
    .NUM_LAYERS(NL), .CONV(0), .PIPE(PIPE),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .TICK_DIV(TD), .ROW_BIT(RB), .COLL_A(0), .COLL_B(1), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_layer(i_layer), .i_pal_we(i_pal_we),
    .i_pal_addr(i_pal_addr), .i_pal_data(i_pal_data), .i_coll_clr(i_coll_clr),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_hpos(o_hpos), .o_vpos(o_vpos), .o_frame_tick(o_frame_tick), .o_game_tick(o_game_tick),
    .o_game_tick_r(o_game_tick_r), .o_row_tick(o_row_tick), .o_collision(o_collision),
    .o_coll_sticky(o_coll_sticky)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference state
  int         t;
  logic [5:0] shadow_m [NL];
  logic [5:0] active_m [NL];
  logic [7:0] pins_m [$];
  bit         sticky_m, prev_gt, prev_vbit;

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < NL; i++) begin
      shadow_m[i] = 6'h3F;
      active_m[i] = 6'h3F;
    end
    pins_m.delete();
    repeat (PIPE) pins_m.push_back(8'hC0);
    sticky_m  = 1'b0;
    prev_gt   = 1'b0;
    prev_vbit = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_pins"}, {o_hsync, o_vsync, o_red, o_green, o_blue}, 8'hC0);
    check({tag, "_hpos"}, o_hpos, 0);
    check({tag, "_vpos"}, o_vpos, 0);
    check({tag, "_ticks"}, {o_frame_tick, o_game_tick, o_game_tick_r, o_row_tick}, 4'b0000);
    check({tag, "_coll"}, {o_collision, o_coll_sticky}, 2'b00);
  endtask

  // One pixel clock: drive, check against the model, advance the model.
  task automatic step(logic [3:0] lay, bit we, logic [1:0] addr, logic [5:0] data, bit clr);
    int h, v, fno, idx;
    bit ft, gt, disp, vbit, coll, hs_e, vs_e;
    logic [5:0] col;
    logic [7:0] pins_e;
    i_layer = lay; i_pal_we = we; i_pal_addr = addr; i_pal_data = data; i_coll_clr = clr;
    #1;
    h    = t % HT;
    v    = (t / HT) % VT;
    ft   = (t % FRAME) == 0;
    fno  = t / FRAME + 1;
    gt   = ft && (fno % TD == 0);
    disp = (h < HA) && (v < VA);
    vbit = ((v >> RB) & 1) != 0;
    coll = disp && lay[0] && lay[1];
    hs_e = !(h >= HA + HF && h < HA + HF + HS);
    vs_e = !(v >= VA + VF && v < VA + VF + VS);
    if (ft) for (int i = 0; i < NL; i++) active_m[i] = shadow_m[i];
    idx = -1;
    for (int i = 0; i < NL; i++) if (lay[i] && idx < 0) idx = i;
    col = (idx >= 0) ? active_m[idx] : BG;
    if (!disp) col = 6'h00;
    pins_e = pins_m.pop_front();
    pins_m.push_back({hs_e, vs_e, col});

    check("hpos", o_hpos, h);
    check("vpos", o_vpos, v);
    check("pins", {o_hsync, o_vsync, o_red, o_green, o_blue}, pins_e);
    check("frame_tick", o_frame_tick, ft);
    check("game_tick", o_game_tick, gt);
    check("game_tick_r", o_game_tick_r, prev_gt);
    check("row_tick", o_row_tick, vbit && !prev_vbit);
    check("collision", o_collision, coll);
    check("coll_sticky", o_coll_sticky, sticky_m);

    if (we) begin
      shadow_m[addr] = data;
      $display("[TB] t=%0d palette write [%0d]=%h", t, addr, data);
    end
    sticky_m  = coll ? 1'b1 : (clr ? 1'b0 : sticky_m);
    prev_gt   = gt;
    prev_vbit = vbit;
    @(posedge clk); #1;
    t++;
  endtask

  task automatic rand_step();
    step(4'($urandom & $urandom), $urandom_range(0, 23) == 0, 2'($urandom), 6'($urandom),
         $urandom_range(0, 7) == 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    i_layer = 4'b0011;
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Frame 1: write in the copy cycle and just after; old palette stays on screen.
    step(4'b0110, 1'b1, 2'd1, 6'h30, 1'b0);
    step(4'b0110, 1'b1, 2'd2, 6'h0C, 1'b0);
    repeat (FRAME - 2) step(4'b0110, 1'b0, 2'd0, 6'h00, 1'b0);
    // Frame 2: layers 1 and 2 now resolve to R=3; collisions race clears; mid-frame write.
    for (int i = 0; i < FRAME; i++)
      step((i % 5 == 0) ? 4'b0011 : 4'b0110, i == FRAME / 2, 2'd0, 6'h03, i % 3 == 0);
    // Frame 3: new palette[0] visible from pixel (0,0).
    repeat (FRAME) step(4'b0001, 1'b0, 2'd0, 6'h00, 1'b0);
    repeat (6 * FRAME) rand_step();

    // Reset mid-frame with a pending shadow write that must be lost.
    step(4'b1000, 1'b1, 2'd3, 6'h0A, 1'b0);
    for (int i = 0; i < FRAME && !(t % HT == 5 && (t / HT) % VT == 3); i++) rand_step();
    i_layer = 4'b0011;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    model_reset();
    repeat (FRAME) step(4'b1000, 1'b0, 2'd0, 6'h00, 1'b0);
    repeat (2 * FRAME) rand_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gfx_compositor.md
# gfx_compositor

Parametrised successor to the single-layer graphics output stage: owns the VGA timing counters, composites NUM_LAYERS prioritised layer-hit bits through a double-buffered 6-bit palette, and drives RGB/sync through a configurable pipeline that keeps colour and sync aligned. Also generates the frame, divided game, and row ticks plus per-frame sticky collision for the game logic. Sits between the game/sprite logic and the board VGA pins.

## Interface
- NUM_LAYERS, 4: layer-hit inputs; index 0 is highest priority (1..8).
- CONV, 0: low position bits dropped on o_hpos/o_vpos.
- PIPE, 2: register stages from i_layer sample to RGB/sync pins (1..4).
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48; V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33: timing; each total ≤ 1024.
- TICK_DIV, 3: frames per game tick (≥1).
- ROW_BIT, 5: vpos bit whose 0→1 edge gives o_row_tick.
- COLL_A, COLL_B, 0/1: layer indices tested for collision (distinct).
- BG_COLOR, 6'h00: {R,G,B} for active pixels with no layer hit.
- LAW = max(1, clog2(NUM_LAYERS)).

- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_layer  in  NUM_LAYERS  layer hits for the pixel at o_hpos/o_vpos, same cycle.
- i_pal_we  in  1  palette shadow write strobe.
- i_pal_addr  in  LAW  layer index written; values ≥ NUM_LAYERS ignored.
- i_pal_data  in  6  {R[1:0],G[1:0],B[1:0]}.
- i_coll_clr  in  1  clears o_coll_sticky.
- o_hsync, o_vsync  out  1  active-low syncs, PIPE-aligned with RGB.
- o_red, o_green, o_blue  out  2  pixel colour.
- o_hpos, o_vpos  out  [9:CONV]  current counter values.
- o_frame_tick  out  1  one-cycle pulse at (0,0).
- o_game_tick  out  1  frame tick on every TICK_DIV-th frame.
- o_game_tick_r  out  1  o_game_tick delayed one cycle.
- o_row_tick  out  1  ROW_BIT rising-edge pulse.
- o_collision  out  1  instantaneous COLL_A∧COLL_B∧display_on.
- o_coll_sticky  out  1  collision seen since last clear.

## Operation
- hpos increments each clk, wraps at H total−1 to 0; vpos increments on that wrap, wraps at V total−1. display_on = hpos<H_ACTIVE ∧ vpos<V_ACTIVE. hsync low for hpos in [H_ACTIVE+H_FP, +H_SYNC); vsync likewise.
- Stage-0 colour: display_on=0 → 6'h00; else lowest set i_layer index → active palette entry; none set → BG_COLOR.
- Colour, hsync, vsync pass through identical PIPE-deep register chain.
- Palette: writes land in shadow any cycle; shadow→active copy on cycle where o_frame_tick=1. Write coincident with the copy cycle lands in shadow and is applied next frame.
- Game tick: frame counter 0..TICK_DIV−1 advances on o_frame_tick; o_game_tick = o_frame_tick ∧ count==TICK_DIV−1.
- o_row_tick = vpos[ROW_BIT] ∧ ¬vpos_bit_r, vpos_bit_r registered each cycle.
- o_coll_sticky sets on o_collision, clears on i_coll_clr; set wins if simultaneous.

## Timing
- Reset (rst_n low, async): hpos=vpos=0, frame count 0, pipeline RGB 0, syncs 1, palette shadow/active all 6'h3F, sticky 0, o_game_tick_r 0, vpos_bit_r 0. o_frame_tick/o_game_tick/o_row_tick/o_collision gated low by rst_n.
- First cycle after release: counters (0,0), o_frame_tick=1, frame count 0→1.
- RGB/sync on pins reflect pixel at counter value PIPE cycles earlier.
- Palette write visible on pins at pixel (0,0) of next frame + PIPE cycles.
- Reset mid-frame: counters, pipeline, palette, sticky all reinitialised; pending shadow writes lost.

## Configuration
- GFX_BLANK_DEBUG_EN: defined → blanking pixels drive {R,G,B}=6'b00_10_11 instead of 6'h00 (bring-up aid); undefined → blanking is black. Syncs/ticks unchanged.

## Test plan
- Reset release, defaults → o_frame_tick at cycle 0, next at cycle 800×525=420000; hsync low 96 cycles starting hpos 656; vsync low lines 490–491.
- i_layer=4'b0110 at active pixel, palette[1]=6'h30, palette[2]=6'h0C → pins show R=3,G=0,B=0 PIPE cycles later with matching syncs.
- Write palette[0]=6'h03 mid-frame → old colour until next (0,0), new colour from then on.
- TICK_DIV=3 → o_game_tick on frames 3,6,9…; o_game_tick_r one cycle after each.
- Layers 0 and 1 both high at active pixel → o_collision=1 same cycle, o_coll_sticky=1 next; i_coll_clr coincident with another hit → stays 1.
- Assert rst_n low at hpos=300,vpos=100 → all outputs at reset values within the same cycle; counters restart at (0,0).
